// File: rtl/sar_cmp_scan.sv
// rtl/sar_cmp_scan.sv - successive-approximation scan controller for the shared comparator
//
// Steps through the enabled channels in ch_en (latched at scan start). For each
// channel it selects the comparator mux, lets it settle, then runs a 10-bit
// binary search on DAC1 using the double-synchronised comparator output.
//
// Ports:
//   clk, srst      system clock, synchronous active-high reset
//   start          one-cycle scan request (ignored while busy)
//   abort          stop everything, clear results (wins over start)
//   cont           continuous mode, sampled when a scan ends
//   ch_en[7:0]     channel enable mask
//   comp_o         asynchronous comparator output (1: input >= DAC)
//   cmp_sel[7:0]   one-hot comparator mux select
//   dac1[9:0]      DAC1 code, dac1_en DAC1 enable
//   busy           scan in progress
//   res_vld        one-cycle result strobe with res_ch[2:0] / res_dat[9:0]
//   scan_done      one-cycle end-of-scan strobe
module sar_cmp_scan #(
  parameter int CH_SETTLE  = 8,
  parameter int BIT_SETTLE = 4
) (
  input  logic       clk,
  input  logic       srst,
  input  logic       start,
  input  logic       abort,
  input  logic       cont,
  input  logic [7:0] ch_en,
  input  logic       comp_o,
  output logic [7:0] cmp_sel,
  output logic [9:0] dac1,
  output logic       dac1_en,
  output logic       busy,
  output logic       res_vld,
  output logic [2:0] res_ch,
  output logic [9:0] res_dat,
  output logic       scan_done
);

  localparam int CNT_MAX = (CH_SETTLE > BIT_SETTLE) ? CH_SETTLE : BIT_SETTLE;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, SEL, TRIAL, STORE} state_t;

  state_t          state, state_n;
  logic [7:0]      mask;
  logic [2:0]      ch;
  logic [3:0]      bit_idx;
  logic [9:0]      code;
  logic [CW-1:0]   cnt;
  logic            sync1, sync2;
  logic [2:0]      res_ch_q;
  logic [9:0]      res_dat_q;
  logic            empty_done;

  logic [7:0]      higher;
  logic [9:0]      trial_code;
  logic [9:0]      new_code;
  logic            sel_end;
  logic            trial_end;
  logic            start_ok;
  logic            relatch;

  // Index of the lowest set bit (0 when none set; callers guard with a non-zero test).
  function automatic logic [2:0] lowest(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

  // Mask bits strictly above channel c; 2<<7 overflows to 0, giving an empty set.
  assign higher     = mask & ~((8'd2 << ch) - 8'd1);
  assign trial_code = code | (10'b1 << bit_idx);
  // The trial bit is kept only when the comparator says input >= trial code.
  assign new_code   = sync2 ? trial_code : code;
  assign sel_end    = (cnt == CW'(CH_SETTLE - 1));
  assign trial_end  = (cnt == CW'(BIT_SETTLE - 1));
  assign start_ok   = start && (|ch_en);
  assign relatch    = cont && (|ch_en);

  assign res_ch  = res_ch_q;
  assign res_dat = res_dat_q;

  always_ff @(posedge clk) begin
    if (srst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    cmp_sel   = 8'h00;
    dac1      = 10'h000;
    dac1_en   = 1'b0;
    busy      = 1'b0;
    res_vld   = 1'b0;
    scan_done = empty_done;
    case (state)
      IDLE: begin
        if (start_ok) state_n = SEL;
      end
      SEL: begin
        cmp_sel = 8'b1 << ch;
        dac1_en = 1'b1;
        busy    = 1'b1;
        if (sel_end) state_n = TRIAL;
      end
      TRIAL: begin
        cmp_sel = 8'b1 << ch;
        dac1    = trial_code;
        dac1_en = 1'b1;
        busy    = 1'b1;
        if (trial_end && (bit_idx == 4'd0)) state_n = STORE;
      end
      STORE: begin
        cmp_sel = 8'b1 << ch;
        dac1    = code;
        dac1_en = 1'b1;
        busy    = 1'b1;
        res_vld = 1'b1;
        if (|higher) begin
          state_n = SEL;
        end else begin
          scan_done = 1'b1;
          state_n   = relatch ? SEL : IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (abort) state_n = IDLE;
  end

  always_ff @(posedge clk) begin
    if (srst || abort) begin
      mask       <= 8'h00;
      ch         <= 3'd0;
      bit_idx    <= 4'd0;
      code       <= 10'h000;
      cnt        <= '0;
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      res_ch_q   <= 3'd0;
      res_dat_q  <= 10'h000;
      empty_done <= 1'b0;
    end else begin
      sync1      <= comp_o;
      sync2      <= sync1;
      // An empty-mask request still acknowledges with a lone scan_done.
      empty_done <= (state == IDLE) && start && !(|ch_en);
      case (state)
        IDLE: begin
          cnt <= '0;
          if (start_ok) begin
            mask <= ch_en;
            ch   <= lowest(ch_en);
          end
        end
        SEL: begin
          if (sel_end) begin
            cnt     <= '0;
            bit_idx <= 4'd9;
            code    <= 10'h000;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        TRIAL: begin
          if (trial_end) begin
            cnt  <= '0;
            code <= new_code;
            if (bit_idx == 4'd0) begin
              res_ch_q  <= ch;
              res_dat_q <= new_code;
            end else begin
              bit_idx <= bit_idx - 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STORE: begin
          cnt <= '0;
          if (|higher) begin
            ch <= lowest(higher);
          end else if (relatch) begin
            mask <= ch_en;
            ch   <= lowest(ch_en);
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_cmp_scan.sv
// tb/tb_sar_cmp_scan.sv - scoreboard bench for sar_cmp_scan
module tb_sar_cmp_scan;

  logic       clk = 1'b0;
  logic       srst, start, abort, cont, comp_o;
  logic [7:0] ch_en;
  logic [7:0] cmp_sel;
  logic [9:0] dac1;
  logic       dac1_en, busy, res_vld, scan_done;
  logic [2:0] res_ch;
  logic [9:0] res_dat;

  logic [9:0] vin [8];

  typedef struct {
    logic [2:0] ch;
    logic [9:0] dat;
    logic       done;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  logic [9:0] dac_log[$];
  logic [9:0] last_dac;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  int         done_cnt = 0;
  int         bad_sel = 0;
  logic [7:0] sel_expect = 8'h00;
  int         base;

  sar_cmp_scan #(.CH_SETTLE(8), .BIT_SETTLE(4)) dut (
    .clk(clk), .srst(srst), .start(start), .abort(abort), .cont(cont),
    .ch_en(ch_en), .comp_o(comp_o), .cmp_sel(cmp_sel), .dac1(dac1),
    .dac1_en(dac1_en), .busy(busy), .res_vld(res_vld), .res_ch(res_ch),
    .res_dat(res_dat), .scan_done(scan_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Ideal comparator on whichever channel the mux selects.
  always_comb begin
    comp_o = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (cmp_sel[i]) comp_o = (vin[i] >= dac1);
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (scan_done) done_cnt++;
    if (busy && sel_expect != 8'h00 && cmp_sel != sel_expect) bad_sel++;
    if (busy && dac1 != last_dac) dac_log.push_back(dac1);
    last_dac = dac1;
    if (res_vld) begin
      if (sb.size() == 0) begin
        check("res_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("res_ch", 32'(res_ch), 32'(e.ch));
        check("res_dat", 32'(res_dat), 32'(e.dat));
        check("res_done", 32'(scan_done), 32'(e.done));
        check("res_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [2:0] c, input logic [9:0] d, input logic dn, input int at);
    exp_t e;
    e.ch = c; e.dat = d; e.done = dn; e.cyc = at;
    sb.push_back(e);
  endtask

  task automatic do_start(input logic [7:0] en, output int b);
    ch_en = en;
    start = 1'b1;
    tick();
    start = 1'b0;
    b = cyc;
    if (en != 8'h00) check("busy_k1", 32'(busy), 32'd1);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) tick();
    check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic outputs_zero(input string tag);
    check({tag, "_busy"},    32'(busy),      32'd0);
    check({tag, "_cmp_sel"}, 32'(cmp_sel),   32'd0);
    check({tag, "_dac1"},    32'(dac1),      32'd0);
    check({tag, "_dac1_en"}, 32'(dac1_en),   32'd0);
    check({tag, "_res_vld"}, 32'(res_vld),   32'd0);
    check({tag, "_res_ch"},  32'(res_ch),    32'd0);
    check({tag, "_res_dat"}, 32'(res_dat),   32'd0);
    check({tag, "_done"},    32'(scan_done), 32'd0);
  endtask

  task automatic single(input string tag, input logic [9:0] v);
    int d0;
    vin[2] = v;
    d0 = done_cnt;
    bad_sel = 0;
    sel_expect = 8'h04;
    do_start(8'h04, base);
    push_exp(3'd2, v, 1'b1, base + 48);
    drain(200);
    tick();
    sel_expect = 8'h00;
    check({tag, "_sel_onehot"}, 32'(bad_sel), 32'd0);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_done_cnt"}, 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    int d0;
    srst = 1'b1; start = 1'b0; abort = 1'b0; cont = 1'b0; ch_en = 8'h00;
    for (int i = 0; i < 8; i++) vin[i] = 10'h000;
    last_dac = 10'h000;
    repeat (3) tick();
    outputs_zero("reset");
    srst = 1'b0;
    tick();

    single("mid", 10'h2A5);

    dac_log.delete();
    single("zero", 10'h000);
    check("dac_log_len", 32'(dac_log.size() >= 10), 32'd1);
    for (int i = 0; i < 10 && i < dac_log.size(); i++)
      check($sformatf("dac_seq_%0d", i), 32'(dac_log[i]), 32'(10'h200 >> i));

    single("full", 10'h3FF);

    // Two channels back to back, one scan_done with the last result.
    vin[0] = 10'h155; vin[7] = 10'h0F0;
    d0 = done_cnt;
    do_start(8'h81, base);
    push_exp(3'd0, 10'h155, 1'b0, base + 48);
    push_exp(3'd7, 10'h0F0, 1'b1, base + 97);
    drain(300);
    tick();
    check("multi_busy_after", 32'(busy), 32'd0);
    check("multi_done_cnt", 32'(done_cnt - d0), 32'd1);

    // Start pulse mid-scan must be ignored.
    vin[4] = 10'h3C3;
    do_start(8'h10, base);
    push_exp(3'd4, 10'h3C3, 1'b1, base + 48);
    repeat (20) tick();
    start = 1'b1; ch_en = 8'h01;
    tick();
    start = 1'b0;
    drain(200);
    repeat (60) tick();
    check("ignore_busy_after", 32'(busy), 32'd0);

    // Continuous mode: mask change takes effect on the next scan only.
    vin[1] = 10'h111; vin[3] = 10'h333;
    cont = 1'b1;
    d0 = done_cnt;
    do_start(8'h02, base);
    push_exp(3'd1, 10'h111, 1'b1, base + 48);
    push_exp(3'd3, 10'h333, 1'b1, base + 97);
    repeat (10) tick();
    ch_en = 8'h08;
    for (int i = 0; i < 200 && sb.size() > 1; i++) tick();
    check("cont_first_timeout", 32'(sb.size()), 32'd1);
    repeat (5) tick();
    check("cont_busy_held", 32'(busy), 32'd1);
    cont = 1'b0;
    drain(200);
    repeat (60) tick();
    check("cont_busy_after", 32'(busy), 32'd0);
    check("cont_done_cnt", 32'(done_cnt - d0), 32'd2);

    // Abort during the bit-5 trial.
    vin[0] = 10'h2AA;
    d0 = done_cnt;
    do_start(8'h01, base);
    check("pre_abort_res_dat", 32'(res_dat), 32'h333);
    while (cyc < base + 25) tick();
    check("abort_dac1", 32'(dac1), 32'h2A0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    outputs_zero("abort");
    repeat (60) tick();
    check("abort_busy_after", 32'(busy), 32'd0);
    check("abort_done_cnt", 32'(done_cnt - d0), 32'd0);

    // Same with synchronous reset, after a completed result.
    single("pre_srst", 10'h0AB);
    d0 = done_cnt;
    do_start(8'h01, base);
    while (cyc < base + 25) tick();
    srst = 1'b1;
    tick();
    srst = 1'b0;
    outputs_zero("srst");
    repeat (60) tick();
    check("srst_done_cnt", 32'(done_cnt - d0), 32'd0);

    // Empty mask: lone scan_done at k+1, never busy.
    do_start(8'h00, base);
    check("empty_done", 32'(scan_done), 32'd1);
    check("empty_busy", 32'(busy), 32'd0);
    tick();
    check("empty_done_clr", 32'(scan_done), 32'd0);
    check("empty_busy2", 32'(busy), 32'd0);

    // start together with abort in IDLE: nothing starts.
    ch_en = 8'h01; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", 32'(busy), 32'd0);
    check("start_abort_done", 32'(scan_done), 32'd0);
    repeat (60) tick();

    check("sb_empty_end", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 0x1 expected 0x0");
    $fatal(1, "timeout");
  end

endmodule
